// File: rtl/pw_usb_packet_filter.sv
`default_nettype none
// ============================================================================
// Module  : pw_usb_packet_filter
// Brief   : Frames sniffed USB bytes into packets, checks PID (and CRC when
//           PW_PKT_CRC_CHECK_EN is defined), forwards mask-enabled PID types.
// Revision: 1.0 - initial release
// ============================================================================
module pw_usb_packet_filter #(
  parameter int pLEN_WIDTH   = 11,
  parameter int pCOUNT_WIDTH = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_n,
  input  logic                    I_arm,
  input  logic [15:0]             I_pid_mask,
  input  logic [7:0]              I_fe_data,
  input  logic                    I_fe_data_valid,
  input  logic                    I_rxactive,
  input  logic                    I_rxerror,
  output logic [7:0]              O_data,
  output logic                    O_data_valid,
  output logic                    O_sop,
  output logic                    O_eop,
  output logic [3:0]              O_pid,
  output logic                    O_pid_err,
  output logic                    O_crc_err,
  output logic [pLEN_WIDTH-1:0]   O_pkt_len,
  output logic [pCOUNT_WIDTH-1:0] O_pkt_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PID  = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam logic [pLEN_WIDTH-1:0] LEN_MAX = {pLEN_WIDTH{1'b1}};

  logic [1:0]              state_q, state_d;
  logic                    arm_q;
  logic                    eop_pend_q, eop_pend_d;
  logic                    pkt_err_q, pkt_err_d;
  logic [pLEN_WIDTH-1:0]   len_q, len_d;

  logic [7:0]              data_q;
  logic                    data_valid_q, sop_q, eop_q;
  logic [3:0]              pid_q;
  logic                    pid_err_q, crc_err_q;
  logic [pLEN_WIDTH-1:0]   pkt_len_q;
  logic [pCOUNT_WIDTH-1:0] pkt_count_q;

  logic w_pid_ok, w_pid_sel, w_arm_rise;
  logic w_pid_byte, w_pid_fwd, w_body_byte, w_eop, w_crc_bad;

  assign w_pid_ok   = (I_fe_data[7:4] == ~I_fe_data[3:0]);
  assign w_pid_sel  = w_pid_ok && I_pid_mask[I_fe_data[3:0]];
  assign w_arm_rise = I_arm && !arm_q;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!I_arm) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (I_rxactive) state_d = ST_PID;
        ST_PID: begin
          if (I_fe_data_valid) state_d = w_pid_sel ? ST_BODY : ST_DROP;
          if (!I_rxactive)     state_d = ST_IDLE;
        end
        ST_BODY, ST_DROP: if (!I_rxactive) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A byte that arrives with rxactive already low closes the packet; its EOP
  // is deferred one cycle so it never coincides with a forwarded byte.
  always_comb begin
    w_pid_byte  = 1'b0;
    w_pid_fwd   = 1'b0;
    w_body_byte = 1'b0;
    w_eop       = 1'b0;
    eop_pend_d  = 1'b0;
    if (I_arm) begin
      w_eop = eop_pend_q;
      case (state_q)
        ST_PID: begin
          w_pid_byte = I_fe_data_valid;
          w_pid_fwd  = I_fe_data_valid && w_pid_sel;
          eop_pend_d = I_fe_data_valid && w_pid_sel && !I_rxactive;
        end
        ST_BODY: begin
          w_body_byte = I_fe_data_valid;
          eop_pend_d  = I_fe_data_valid && !I_rxactive;
          if (!I_fe_data_valid && !I_rxactive) w_eop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    len_d     = len_q;
    pkt_err_d = pkt_err_q;
    if (w_pid_fwd) begin
      len_d     = {{(pLEN_WIDTH-1){1'b0}}, 1'b1};
      pkt_err_d = I_rxerror;
    end else begin
      if (w_body_byte && (len_q != LEN_MAX)) len_d = len_q + 1'b1;
      if ((state_q == ST_BODY) && I_rxerror) pkt_err_d = 1'b1;
    end
  end

`ifdef PW_PKT_CRC_CHECK_EN
  localparam logic [1:0] CRC_NONE = 2'd0;
  localparam logic [1:0] CRC_5    = 2'd1;
  localparam logic [1:0] CRC_16   = 2'd2;

  logic [1:0]  crc_kind_q, crc_kind_d;
  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;

  // Bytes arrive LSB first on the wire, so bit 0 is shifted in first.
  function automatic logic [4:0] f_crc5(input logic [4:0] c, input logic [7:0] d);
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[3:0], 1'b0} ^ ((r[4] ^ d[i]) ? 5'h05 : 5'h00);
    return r;
  endfunction

  function automatic logic [15:0] f_crc16(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h8005 : 16'h0000);
    return r;
  endfunction

  always_comb begin
    crc_kind_d = crc_kind_q;
    crc5_d     = crc5_q;
    crc16_d    = crc16_q;
    if (w_pid_fwd) begin
      crc5_d  = 5'h1F;
      crc16_d = 16'hFFFF;
      case (I_fe_data[3:0])
        4'h1, 4'h5, 4'h9, 4'hD: crc_kind_d = CRC_5;
        4'h3, 4'h7, 4'hB, 4'hF: crc_kind_d = CRC_16;
        default:                crc_kind_d = CRC_NONE;
      endcase
    end else if (w_body_byte) begin
      crc5_d  = f_crc5(crc5_q, I_fe_data);
      crc16_d = f_crc16(crc16_q, I_fe_data);
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_kind_q <= CRC_NONE;
      crc5_q     <= 5'h1F;
      crc16_q    <= 16'hFFFF;
    end else begin
      crc_kind_q <= crc_kind_d;
      crc5_q     <= crc5_d;
      crc16_q    <= crc16_d;
    end
  end

  assign w_crc_bad = ((crc_kind_q == CRC_5)  && (crc5_q  != 5'h0C)) ||
                     ((crc_kind_q == CRC_16) && (crc16_q != 16'h800D));
`else
  assign w_crc_bad = 1'b0;
`endif

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q        <= 1'b0;
      eop_pend_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      len_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      pid_q        <= '0;
      pid_err_q    <= 1'b0;
      crc_err_q    <= 1'b0;
      pkt_len_q    <= '0;
      pkt_count_q  <= '0;
    end else begin
      arm_q        <= I_arm;
      eop_pend_q   <= eop_pend_d;
      pkt_err_q    <= pkt_err_d;
      len_q        <= len_d;
      data_valid_q <= w_pid_fwd || w_body_byte;
      sop_q        <= w_pid_fwd;
      eop_q        <= w_eop;
      if (w_pid_fwd || w_body_byte) data_q <= I_fe_data;
      if (w_pid_byte && w_pid_ok)   pid_q  <= I_fe_data[3:0];
      if (w_eop) begin
        crc_err_q <= pkt_err_q || w_crc_bad;
        pkt_len_q <= len_q;
      end
      if (w_arm_rise) begin
        pkt_count_q <= '0;
        pid_err_q   <= 1'b0;
      end else begin
        if (w_eop)                   pkt_count_q <= pkt_count_q + 1'b1;
        if (w_pid_byte && !w_pid_ok) pid_err_q   <= 1'b1;
      end
    end
  end

  assign O_data       = data_q;
  assign O_data_valid = data_valid_q;
  assign O_sop        = sop_q;
  assign O_eop        = eop_q;
  assign O_pid        = pid_q;
  assign O_pid_err    = pid_err_q;
  assign O_crc_err    = crc_err_q;
  assign O_pkt_len    = pkt_len_q;
  assign O_pkt_count  = pkt_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pw_usb_packet_filter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pw_usb_packet_filter
// Brief   : Randomized bench for pw_usb_packet_filter with a packet-level
//           reference model (CRC expectations follow PW_PKT_CRC_CHECK_EN).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pw_usb_packet_filter;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [10:0] len;
    logic        crc_err;
    logic [15:0] cnt;
    logic [3:0]  pid;
  } eop_t;

`ifdef PW_PKT_CRC_CHECK_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic        fe_clk = 1'b0;
  logic        reset_n;
  logic        I_arm;
  logic [15:0] I_pid_mask;
  logic [7:0]  I_fe_data;
  logic        I_fe_data_valid;
  logic        I_rxactive;
  logic        I_rxerror;
  logic [7:0]  O_data;
  logic        O_data_valid;
  logic        O_sop;
  logic        O_eop;
  logic [3:0]  O_pid;
  logic        O_pid_err;
  logic        O_crc_err;
  logic [10:0] O_pkt_len;
  logic [15:0] O_pkt_count;

  always #5 fe_clk = ~fe_clk;

  pw_usb_packet_filter #(.pLEN_WIDTH(11), .pCOUNT_WIDTH(16)) dut (
    .fe_clk          (fe_clk),
    .reset_n         (reset_n),
    .I_arm           (I_arm),
    .I_pid_mask      (I_pid_mask),
    .I_fe_data       (I_fe_data),
    .I_fe_data_valid (I_fe_data_valid),
    .I_rxactive      (I_rxactive),
    .I_rxerror       (I_rxerror),
    .O_data          (O_data),
    .O_data_valid    (O_data_valid),
    .O_sop           (O_sop),
    .O_eop           (O_eop),
    .O_pid           (O_pid),
    .O_pid_err       (O_pid_err),
    .O_crc_err       (O_crc_err),
    .O_pkt_len       (O_pkt_len),
    .O_pkt_count     (O_pkt_count)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  bq_t         pkt;
  logic [8:0]  exp_bytes[$];
  eop_t        exp_eops[$];
  eop_t        mon_e;
  logic [15:0] m_count;
  logic        m_pid_err;
  logic [3:0]  m_pid;
  bit          m_arm;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reflected (wire-order) CRC generators; results are the complemented
  // values a USB transmitter appends.
  function automatic logic [4:0] ref_crc5(input logic [10:0] v);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ v[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return ~c;
  endfunction

  function automatic logic [15:0] ref_crc16(input bq_t q, input int lo, input int n);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int k = lo; k < lo + n; k++) begin
      b = q[k];
      for (int j = 0; j < 8; j++) c = (c[0] ^ b[j]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit crc_ok(input bq_t q);
    logic [7:0]  p0;
    logic [15:0] w;
    p0 = q[0];
    case (p0[3:0])
      4'h1, 4'h5, 4'h9, 4'hD: begin
        if (q.size() != 3) return 1'b0;
        w = {q[2], q[1]};
        return w[15:11] == ref_crc5(w[10:0]);
      end
      4'h3, 4'h7, 4'hB, 4'hF: begin
        if (q.size() < 3) return 1'b0;
        w = {q[q.size()-1], q[q.size()-2]};
        return w == ref_crc16(q, 1, q.size() - 3);
      end
      default: return 1'b1;
    endcase
  endfunction

  task automatic expect_pkt(input int err_at, input int drop_at);
    logic [7:0] p0;
    int         nf;
    eop_t       e;
    if (!m_arm) return;
    p0 = pkt[0];
    nf = (drop_at < 0) ? pkt.size() : drop_at;
    if (nf == 0) return;
    if (p0[7:4] != ~p0[3:0]) begin
      m_pid_err = 1'b1;
      return;
    end
    m_pid = p0[3:0];
    if (!I_pid_mask[p0[3:0]]) return;
    for (int i = 0; i < nf; i++) exp_bytes.push_back({(i == 0), pkt[i]});
    if (drop_at >= 0) return;
    m_count   = m_count + 16'd1;
    e.len     = (pkt.size() > 2047) ? 11'd2047 : 11'(pkt.size());
    e.crc_err = (err_at >= 0) || (CRC_EN && !crc_ok(pkt));
    e.cnt     = m_count;
    e.pid     = p0[3:0];
    exp_eops.push_back(e);
  endtask

  task automatic send(input int err_at, input int drop_at, input bit fall_last, input int gap);
    expect_pkt(err_at, drop_at);
    @(negedge fe_clk);
    I_rxactive = 1'b1; I_fe_data_valid = 1'b0; I_rxerror = 1'b0;
    for (int i = 0; i < pkt.size(); i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(negedge fe_clk);
        I_fe_data_valid = 1'b0; I_rxerror = 1'b0;
      end
      @(negedge fe_clk);
      I_fe_data_valid = 1'b1;
      I_fe_data       = pkt[i];
      I_rxerror       = (i == err_at);
      if (i == drop_at) begin I_arm = 1'b0; m_arm = 1'b0; end
      if (fall_last && (i == pkt.size() - 1)) I_rxactive = 1'b0;
    end
    @(negedge fe_clk);
    I_fe_data_valid = 1'b0; I_rxerror = 1'b0; I_rxactive = 1'b0;
    for (int g = 1; g < gap; g++) begin
      @(negedge fe_clk);
      I_fe_data_valid = 1'($urandom % 2);
      I_fe_data       = 8'($urandom);
    end
    I_fe_data_valid = 1'b0;
  endtask

  task automatic set_arm(input bit v);
    @(negedge fe_clk);
    I_arm = v;
    if (v && !m_arm) begin m_count = '0; m_pid_err = 1'b0; end
    m_arm = v;
  endtask

  task automatic idle_check(input string tag);
    repeat (4) @(negedge fe_clk);
    check_val({tag, "_count"},   32'(O_pkt_count), 32'(m_count));
    check_val({tag, "_pid_err"}, 32'(O_pid_err),   32'(m_pid_err));
    check_val({tag, "_pid"},     32'(O_pid),       32'(m_pid));
    check_val({tag, "_bytes_left"}, 32'(exp_bytes.size()), 32'd0);
    check_val({tag, "_eops_left"},  32'(exp_eops.size()),  32'd0);
  endtask

  task automatic build_rand();
    logic [3:0]  nib;
    logic [7:0]  pid;
    logic [10:0] field;
    logic [15:0] w;
    int          n;
    nib = 4'($urandom);
    pid = {~nib, nib};
    if ($urandom % 10 == 0) pid[7:4] = pid[7:4] ^ 4'(1 << ($urandom % 4));
    pkt.delete();
    pkt.push_back(pid);
    case (nib)
      4'h1, 4'h5, 4'h9, 4'hD: begin
        field = 11'($urandom);
        w = {ref_crc5(field), field};
        pkt.push_back(w[7:0]); pkt.push_back(w[15:8]);
      end
      4'h3, 4'h7, 4'hB, 4'hF: begin
        n = $urandom_range(0, 8);
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
        w = ref_crc16(pkt, 1, n);
        pkt.push_back(w[7:0]); pkt.push_back(w[15:8]);
      end
      4'h2, 4'h6, 4'hA, 4'hE: ;
      default: begin
        n = $urandom_range(0, 3);
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      end
    endcase
    if (pkt.size() >= 3 && ($urandom % 6 == 0)) begin
      n = $urandom_range(1, pkt.size() - 1);
      pkt[n] = pkt[n] ^ 8'(1 << ($urandom % 8));
    end
  endtask

  always @(negedge fe_clk) begin
    if (reset_n) begin
      if (O_data_valid) begin
        check_val("byte_expected", 32'(exp_bytes.size() != 0), 32'd1);
        if (exp_bytes.size() != 0)
          check_val("byte_sop_data", {23'd0, O_sop, O_data}, {23'd0, exp_bytes.pop_front()});
      end
      if (O_eop) begin
        check_val("eop_dv_low", 32'(O_data_valid), 32'd0);
        check_val("eop_expected", 32'(exp_eops.size() != 0), 32'd1);
        if (exp_eops.size() != 0) begin
          mon_e = exp_eops.pop_front();
          check_val("eop_len",     32'(O_pkt_len),   32'(mon_e.len));
          check_val("eop_crc_err", 32'(O_crc_err),   32'(mon_e.crc_err));
          check_val("eop_count",   32'(O_pkt_count), 32'(mon_e.cnt));
          check_val("eop_pid",     32'(O_pid),       32'(mon_e.pid));
        end
      end
    end
  end

  initial begin
    logic [15:0] w;
    int          err, drop;
    reset_n = 1'b0; I_arm = 1'b0; I_pid_mask = '0; I_fe_data = '0;
    I_fe_data_valid = 1'b0; I_rxactive = 1'b0; I_rxerror = 1'b0;
    m_count = '0; m_pid_err = 1'b0; m_pid = '0; m_arm = 1'b0;
    repeat (3) @(negedge fe_clk);
    check_val("rst_data",    32'(O_data),       32'd0);
    check_val("rst_dv",      32'(O_data_valid), 32'd0);
    check_val("rst_sop",     32'(O_sop),        32'd0);
    check_val("rst_eop",     32'(O_eop),        32'd0);
    check_val("rst_pid",     32'(O_pid),        32'd0);
    check_val("rst_pid_err", 32'(O_pid_err),    32'd0);
    check_val("rst_crc_err", 32'(O_crc_err),    32'd0);
    check_val("rst_len",     32'(O_pkt_len),    32'd0);
    check_val("rst_count",   32'(O_pkt_count),  32'd0);
    @(negedge fe_clk);
    reset_n = 1'b1;
    set_arm(1'b1);

    I_pid_mask = 16'hFFFF;
    pkt = '{8'h2D, 8'h00, 8'h10};
    send(-1, -1, 1'b0, 2);
    idle_check("setup");
    check_val("setup_len", 32'(O_pkt_len), 32'd3);
    check_val("setup_crc", 32'(O_crc_err), 32'd0);

    I_pid_mask = 16'h0008;
    pkt = '{8'hD2};
    send(-1, -1, 1'b0, 2);
    pkt = '{8'hC3, 8'h00, 8'h00};
    send(-1, -1, 1'b0, 2);
    idle_check("data0_only");

    I_pid_mask = 16'hFFFF;
    pkt = '{8'h2E, 8'h00};
    send(-1, -1, 1'b0, 2);
    idle_check("bad_pid");
    check_val("bad_pid_sticky", 32'(O_pid_err), 32'd1);

    pkt = '{8'hC3, 8'h00, 8'h01};
    send(-1, -1, 1'b0, 2);
    idle_check("crc_bad");
    check_val("crc_bad_flag", 32'(O_crc_err), 32'(CRC_EN));

    pkt = '{8'hC3, 8'h11, 8'h22};
    w = ref_crc16(pkt, 1, 2);
    pkt.push_back(w[7:0]); pkt.push_back(w[15:8]);
    send(2, -1, 1'b0, 2);
    idle_check("rxerror");
    check_val("rxerror_flag", 32'(O_crc_err), 32'd1);

    pkt = '{8'hC3, 8'h01, 8'h02, 8'h03};
    send(-1, 2, 1'b0, 2);
    set_arm(1'b1);
    idle_check("rearm");
    check_val("rearm_count", 32'(O_pkt_count), 32'd0);

    w[10:0] = 11'h2A5;
    w = {ref_crc5(w[10:0]), w[10:0]};
    pkt = '{8'hA5, w[7:0], w[15:8]};
    send(-1, -1, 1'b0, 1);
    pkt = '{8'hD2};
    send(-1, -1, 1'b0, 3);
    idle_check("b2b");
    check_val("b2b_last_len", 32'(O_pkt_len), 32'd1);

    @(negedge fe_clk); I_rxactive = 1'b1;
    @(negedge fe_clk);
    @(negedge fe_clk); I_rxactive = 1'b0;
    idle_check("pid_abort");

    pkt = '{8'hD2};
    send(-1, -1, 1'b1, 1);
    pkt = '{8'h4B, 8'h00, 8'h00};
    send(-1, -1, 1'b1, 2);
    idle_check("fall_with_last");

    set_arm(1'b0);
    pkt = '{8'hC3, 8'h00, 8'h00};
    send(-1, -1, 1'b0, 2);
    set_arm(1'b1);
    idle_check("disarmed");

    pkt = '{8'h4B};
    for (int i = 0; i < 2100; i++) pkt.push_back(8'($urandom));
    w = ref_crc16(pkt, 1, 2100);
    pkt.push_back(w[7:0]); pkt.push_back(w[15:8]);
    send(-1, -1, 1'b0, 2);
    idle_check("len_sat");

    for (int p = 0; p < 160; p++) begin
      if (p % 10 == 0) I_pid_mask = 16'($urandom | $urandom);
      build_rand();
      err  = (pkt.size() > 1 && ($urandom % 7 == 0)) ? $urandom_range(1, pkt.size() - 1) : -1;
      drop = (pkt.size() > 2 && ($urandom % 15 == 0)) ? $urandom_range(1, pkt.size() - 1) : -1;
      send(err, drop, 1'($urandom % 4 == 0), $urandom_range(1, 3));
      if (drop >= 0) set_arm(1'b1);
      if ($urandom % 4 == 0) idle_check("rand");
    end
    idle_check("final");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
